trace_capture: RTL and testbench

Synthesizable commit-trace recorder for the single-cycle CPU (sccomp). It records each retired instruction (PC, instruction word, register write-back) into a circular buffer and stops on a programmable stop PC, a commit-count limit, or a misaligned PC. The buffer is read back oldest-first through a registered read port. It sits beside the CPU core, fed from its write-back signals, and replaces per-cycle register dumps with an on-chip record usable on FPGA.

---
 rtl/trace_pkg.sv | 26 ++
 rtl/trace_ram.sv | 30 +++
 rtl/trace_capture.sv | 129 ++++++++++++
 tb/tb_trace_capture.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the commit-trace recorder: FSM states, stop causes and the
// packed entry stored per retired instruction.
package trace_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_POST    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_STOPPC = 2'd1;
  localparam logic [1:0] CAUSE_LIMIT  = 2'd2;
  localparam logic [1:0] CAUSE_BADPC  = 2'd3;

  // 32 + 32 + 1 + 5 + 32 = 102 bits
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace store: one write port, one registered read port.
// Read-during-write to the same slot returns the previous contents.
module trace_ram
  import trace_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  trace_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output trace_entry_t rdata
);

  trace_entry_t mem [DEPTH];

  // Array itself is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_capture.sv
// Commit-trace recorder: circular buffer of retired instructions with
// stop-PC / commit-limit / misaligned-PC triggers and oldest-first readback.
module trace_capture
  import trace_pkg::*;
#(
  parameter int          DEPTH       = 64,
  parameter int unsigned MAX_COMMITS = 1000,
  parameter int unsigned POST_CNT    = 0,
  localparam int         AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          arm,
  input  logic          stop_pc_en,
  input  logic [31:0]   stop_pc,
  input  logic          commit_valid,
  input  logic [31:0]   commit_pc,
  input  logic [31:0]   commit_instr,
  input  logic          commit_we,
  input  logic [4:0]    commit_wa,
  input  logic [31:0]   commit_wd,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_pc,
  output logic [31:0]   rd_instr,
  output logic [31:0]   rd_wd,
  output logic          rd_we,
  output logic [4:0]    rd_wa,
  output logic [AW:0]   entries,
  output logic          wrapped,
  output logic          busy,
  output logic          done,
  output logic [1:0]    cause,
  output logic [31:0]   commits
);

  state_t       st, st_n;
  logic [1:0]   cause_n;
  logic [31:0]  post_cnt, post_n;
  logic [AW-1:0] wptr, raddr;
  logic         wr_en, bad_pc, stop_hit, lim_hit;
  trace_entry_t wdata, rdata;

  // arm takes precedence: a commit in the arm cycle is dropped.
  assign wr_en    = commit_valid && !arm && (st == S_CAPTURE || st == S_POST);
  assign bad_pc   = commit_pc[1:0] != 2'b00;
  assign stop_hit = stop_pc_en && (commit_pc == stop_pc) && (st == S_CAPTURE);
  assign lim_hit  = (MAX_COMMITS != 0) &&
                    (({1'b0, commits} + 33'd1) == {1'b0, MAX_COMMITS});

  always_comb begin
    st_n    = st;
    cause_n = cause;
    post_n  = post_cnt;
    if (arm) begin
      st_n    = S_CAPTURE;
      cause_n = CAUSE_NONE;
    end else if (wr_en) begin
      if (bad_pc) begin
        st_n    = S_DONE;
        cause_n = CAUSE_BADPC;
      end else if (stop_hit) begin
        cause_n = CAUSE_STOPPC;
        if (POST_CNT == 0) st_n = S_DONE;
        else begin
          st_n   = S_POST;
          post_n = POST_CNT;
        end
      end else if (lim_hit) begin
        st_n    = S_DONE;
        cause_n = CAUSE_LIMIT;
      end else if (st == S_POST) begin
        post_n = post_cnt - 32'd1;
        if (post_cnt == 32'd1) st_n = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st       <= S_IDLE;
      cause    <= CAUSE_NONE;
      post_cnt <= '0;
      wptr     <= '0;
      entries  <= '0;
      wrapped  <= 1'b0;
      commits  <= '0;
    end else begin
      st       <= st_n;
      cause    <= cause_n;
      post_cnt <= post_n;
      if (arm) begin
        wptr    <= '0;
        entries <= '0;
        wrapped <= 1'b0;
        commits <= '0;
      end else if (wr_en) begin
        wptr <= wptr + 1'b1;
        if (commits != 32'hFFFF_FFFF) commits <= commits + 32'd1;
        if (entries == (AW+1)'(DEPTH)) wrapped <= 1'b1;
        else                           entries <= entries + 1'b1;
      end
    end
  end

  // Once wrapped, the write pointer sits on the oldest surviving entry.
  assign raddr = (wrapped ? wptr : '0) + rd_idx;

  assign wdata = '{pc: commit_pc, instr: commit_instr, we: commit_we,
                   wa: commit_wa, wd: commit_wd};

  trace_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign rd_pc    = rdata.pc;
  assign rd_instr = rdata.instr;
  assign rd_wd    = rdata.wd;
  assign rd_we    = rdata.we;
  assign rd_wa    = rdata.wa;
  assign busy     = (st == S_CAPTURE) || (st == S_POST);
  assign done     = (st == S_DONE);

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: three configurations share the commit
// stream; each is armed individually and checked against a scoreboard.
module tb_trace_capture;
  import trace_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        arm_a, arm_b, arm_c, stop_pc_en, commit_valid, commit_we;
  logic [31:0] stop_pc, commit_pc, commit_instr, commit_wd;
  logic [4:0]  commit_wa;
  logic [5:0]  a_idx, c_idx;
  logic [1:0]  b_idx;

  logic [31:0] a_pc, a_instr, a_wd, a_commits, b_pc, b_instr, b_wd, b_commits;
  logic [31:0] c_pc, c_instr, c_wd, c_commits;
  logic        a_we, a_wrapped, a_busy, a_done, b_we, b_wrapped, b_busy, b_done;
  logic        c_we, c_wrapped, c_busy, c_done;
  logic [4:0]  a_wa, b_wa, c_wa;
  logic [1:0]  a_cause, b_cause, c_cause;
  logic [6:0]  a_ent, c_ent;
  logic [2:0]  b_ent;

  trace_capture #(.DEPTH(64), .MAX_COMMITS(1000), .POST_CNT(0)) dut_a (
    .clk(clk), .rstn(rstn), .arm(arm_a), .stop_pc_en(stop_pc_en), .stop_pc(stop_pc),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .commit_we(commit_we), .commit_wa(commit_wa), .commit_wd(commit_wd), .rd_idx(a_idx),
    .rd_pc(a_pc), .rd_instr(a_instr), .rd_wd(a_wd), .rd_we(a_we), .rd_wa(a_wa),
    .entries(a_ent), .wrapped(a_wrapped), .busy(a_busy), .done(a_done),
    .cause(a_cause), .commits(a_commits));

  trace_capture #(.DEPTH(4), .MAX_COMMITS(10), .POST_CNT(0)) dut_b (
    .clk(clk), .rstn(rstn), .arm(arm_b), .stop_pc_en(stop_pc_en), .stop_pc(stop_pc),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .commit_we(commit_we), .commit_wa(commit_wa), .commit_wd(commit_wd), .rd_idx(b_idx),
    .rd_pc(b_pc), .rd_instr(b_instr), .rd_wd(b_wd), .rd_we(b_we), .rd_wa(b_wa),
    .entries(b_ent), .wrapped(b_wrapped), .busy(b_busy), .done(b_done),
    .cause(b_cause), .commits(b_commits));

  trace_capture #(.DEPTH(64), .MAX_COMMITS(1000), .POST_CNT(2)) dut_c (
    .clk(clk), .rstn(rstn), .arm(arm_c), .stop_pc_en(stop_pc_en), .stop_pc(stop_pc),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .commit_we(commit_we), .commit_wa(commit_wa), .commit_wd(commit_wd), .rd_idx(c_idx),
    .rd_pc(c_pc), .rd_instr(c_instr), .rd_wd(c_wd), .rd_we(c_we), .rd_wa(c_wa),
    .entries(c_ent), .wrapped(c_wrapped), .busy(c_busy), .done(c_done),
    .cause(c_cause), .commits(c_commits));

  int checks = 0;
  int errors = 0;
  int mdepth = 64;
  trace_entry_t model_q[$];
  trace_entry_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int d);
    if (d == 0) arm_a = 1'b1; else if (d == 1) arm_b = 1'b1; else arm_c = 1'b1;
    tick();
    arm_a = 1'b0; arm_b = 1'b0; arm_c = 1'b0;
    model_q.delete();
  endtask

  // Drives one retired instruction; when push is set the model records it.
  task automatic commit(input logic [31:0] pc, input bit push);
    trace_entry_t e;
    e.pc = pc; e.instr = pc ^ 32'h1357_9BDF; e.we = pc[2]; e.wa = pc[6:2];
    e.wd = ~pc + 32'h11;
    commit_valid = 1'b1; commit_pc = e.pc; commit_instr = e.instr;
    commit_we = e.we; commit_wa = e.wa; commit_wd = e.wd;
    if (push) begin
      model_q.push_back(e);
      if (model_q.size() > mdepth) void'(model_q.pop_front());
    end
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic status(input string tag, input int d, input int ent, input bit wr,
                        input bit bz, input bit dn, input int cs, input int cm);
    logic [31:0] o_ent, o_cm;
    logic        o_wr, o_bz, o_dn;
    logic [1:0]  o_cs;
    case (d)
      0:       begin o_ent = 32'(a_ent); o_wr = a_wrapped; o_bz = a_busy; o_dn = a_done; o_cs = a_cause; o_cm = a_commits; end
      1:       begin o_ent = 32'(b_ent); o_wr = b_wrapped; o_bz = b_busy; o_dn = b_done; o_cs = b_cause; o_cm = b_commits; end
      default: begin o_ent = 32'(c_ent); o_wr = c_wrapped; o_bz = c_busy; o_dn = c_done; o_cs = c_cause; o_cm = c_commits; end
    endcase
    chk({tag, ".entries"}, o_ent, 32'(ent));
    chk({tag, ".wrapped"}, 32'(o_wr), 32'(wr));
    chk({tag, ".busy"},    32'(o_bz), 32'(bz));
    chk({tag, ".done"},    32'(o_dn), 32'(dn));
    chk({tag, ".cause"},   32'(o_cs), 32'(cs));
    chk({tag, ".commits"}, o_cm, 32'(cm));
  endtask

  task automatic set_idx(input int d, input int i);
    if (d == 0) a_idx = 6'(i); else if (d == 1) b_idx = 2'(i); else c_idx = 6'(i);
  endtask

  task automatic get_rd(input int d, output trace_entry_t g);
    case (d)
      0:       g = '{pc: a_pc, instr: a_instr, we: a_we, wa: a_wa, wd: a_wd};
      1:       g = '{pc: b_pc, instr: b_instr, we: b_we, wa: b_wa, wd: b_wd};
      default: g = '{pc: c_pc, instr: c_instr, we: c_we, wa: c_wa, wd: c_wd};
    endcase
  endtask

  // Oldest-first readback of n entries against the model.
  task automatic readback(input string tag, input int d, input int n);
    trace_entry_t g, e;
    for (int i = 0; i < n; i++) begin
      set_idx(d, i);
      exp_q.push_back(model_q[i]);
      tick();
      get_rd(d, g);
      e = exp_q.pop_front();
      chk($sformatf("%s.rd%0d.pc", tag, i), g.pc, e.pc);
      chk($sformatf("%s.rd%0d.instr", tag, i), g.instr, e.instr);
      chk($sformatf("%s.rd%0d.wd", tag, i), g.wd, e.wd);
      chk($sformatf("%s.rd%0d.wewa", tag, i), 32'({g.we, g.wa}), 32'({e.we, e.wa}));
    end
  endtask

  task automatic rd_pc_at(input string tag, input int d, input int i, input logic [31:0] pc);
    trace_entry_t g;
    set_idx(d, i);
    tick();
    get_rd(d, g);
    chk(tag, g.pc, pc);
  endtask

  initial begin
    rstn = 1'b0; arm_a = 1'b0; arm_b = 1'b0; arm_c = 1'b0;
    stop_pc_en = 1'b0; stop_pc = '0; commit_valid = 1'b0; commit_pc = '0;
    commit_instr = '0; commit_we = 1'b0; commit_wa = '0; commit_wd = '0;
    a_idx = '0; b_idx = '0; c_idx = '0;
    tick(); tick();
    status("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.rd_pc", a_pc, 32'h0);
    rstn = 1'b1;
    tick();

    // Commits with no arm are ignored.
    for (int k = 0; k < 5; k++) commit(32'(k * 4), 1'b0);
    status("noarm", 0, 0, 0, 0, 0, 0, 0);

    // Stop-PC trigger with no post-capture.
    stop_pc = 32'h48; stop_pc_en = 1'b1; mdepth = 64;
    pulse(0);
    for (int k = 0; k < 18; k++) commit(32'(k * 4), 1'b1);
    status("stoppc.pre", 0, 18, 0, 1, 0, 0, 18);
    commit(32'h48, 1'b1);
    status("stoppc", 0, 19, 0, 0, 1, 1, 19);
    readback("stoppc", 0, 19);
    rd_pc_at("stoppc.idx18", 0, 18, 32'h48);
    commit(32'h4C, 1'b0);
    status("stoppc.after", 0, 19, 0, 0, 1, 1, 19);

    // Commit limit with wrap in a 4-deep buffer.
    stop_pc_en = 1'b0; mdepth = 4;
    pulse(1);
    for (int k = 0; k < 9; k++) commit(32'h100 + 32'(k * 4), 1'b1);
    status("limit.pre", 1, 4, 1, 1, 0, 0, 9);
    commit(32'h124, 1'b1);
    status("limit", 1, 4, 1, 0, 1, 2, 10);
    readback("limit", 1, 4);
    rd_pc_at("limit.idx0", 1, 0, 32'h118);
    rd_pc_at("limit.idx3", 1, 3, 32'h124);

    // Stop-PC with two post-trigger entries.
    stop_pc = 32'h08; stop_pc_en = 1'b1; mdepth = 64;
    pulse(2);
    commit(32'h00, 1'b1); commit(32'h04, 1'b1); commit(32'h08, 1'b1);
    status("post.trig", 2, 3, 0, 1, 0, 1, 3);
    commit(32'h0C, 1'b1);
    status("post.mid", 2, 4, 0, 1, 0, 1, 4);
    commit(32'h10, 1'b1);
    status("post.done", 2, 5, 0, 0, 1, 1, 5);
    commit(32'h14, 1'b0);
    status("post.after", 2, 5, 0, 0, 1, 1, 5);
    readback("post", 2, 5);

    // Misaligned PC stops immediately and is itself stored.
    stop_pc_en = 1'b0;
    pulse(0);
    commit(32'h0000_0042, 1'b1);
    status("badpc", 0, 1, 0, 0, 1, 3, 1);
    readback("badpc", 0, 1);

    // Re-arm mid-capture discards earlier entries.
    pulse(0);
    commit(32'h200, 1'b1); commit(32'h204, 1'b1); commit(32'h208, 1'b1);
    pulse(0);
    commit(32'h300, 1'b1); commit(32'h304, 1'b1);
    status("rearm", 0, 2, 0, 1, 0, 0, 2);
    readback("rearm", 0, 2);

    // arm and commit in the same cycle: the commit is dropped.
    arm_a = 1'b1; commit(32'h400, 1'b0); arm_a = 1'b0;
    status("armcommit", 0, 0, 0, 1, 0, 0, 0);

    // Reset asserted while in POST.
    stop_pc = 32'h500; stop_pc_en = 1'b1;
    pulse(2);
    commit(32'h4FC, 1'b1); commit(32'h500, 1'b1);
    status("rst.post", 2, 2, 0, 1, 0, 1, 2);
    rstn = 1'b0;
    #2;
    status("rst.async", 2, 0, 0, 0, 0, 0, 0);
    chk("rst.rd_pc", c_pc, 32'h0);
    chk("rst.rd_wd", c_wd, 32'h0);
    tick();
    rstn = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
